// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state encoding and default widths for the frame timer
package frame_pkg;

    localparam int PIX_W_DEF  = 6;
    localparam int LINE_W_DEF = 5;
    localparam int FRM_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } frame_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - up-counter that returns to zero after reaching max
// wrap flags the enabled cycle in which the count sits at max and will roll over.
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && !clr && (count == max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == max) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - pixel/line raster timer with free-run and single-shot frames
// Limits and mode are captured at start so a running frame is immune to input changes.
module frame_timer
    import frame_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int FRM_W  = FRM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              clr,
    input  logic              start,
    input  logic              mode,
    input  logic [PIX_W-1:0]  pix_max,
    input  logic [LINE_W-1:0] line_max,
    output logic [PIX_W-1:0]  pix_idx,
    output logic [LINE_W-1:0] line_idx,
    output logic              newLine,
    output logic              endFrame,
    output logic              busy,
    output logic [FRM_W-1:0]  frm_cnt
);

    frame_state_t      state;
    logic [PIX_W-1:0]  sh_pix_max;
    logic [LINE_W-1:0] sh_line_max;
    logic              sh_mode;
    logic              cnt_en;
    logic              pix_wrap;
    logic              line_wrap;

    assign cnt_en = (state == RUN) && enb && !clr;

    wrap_counter #(.W(PIX_W)) u_pix (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .clr   (clr),
        .max   (sh_pix_max),
        .count (pix_idx),
        .wrap  (pix_wrap)
    );

    // The line counter only advances on a pixel wrap, so its wrap marks frame end.
    wrap_counter #(.W(LINE_W)) u_line (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_wrap),
        .clr   (clr),
        .max   (sh_line_max),
        .count (line_idx),
        .wrap  (line_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sh_pix_max  <= '0;
            sh_line_max <= '0;
            sh_mode     <= 1'b0;
            newLine     <= 1'b0;
            endFrame    <= 1'b0;
            busy        <= 1'b0;
            frm_cnt     <= '0;
        end else if (clr) begin
            state    <= IDLE;
            newLine  <= 1'b0;
            endFrame <= 1'b0;
            busy     <= 1'b0;
            frm_cnt  <= '0;
        end else begin
            newLine  <= pix_wrap;
            endFrame <= line_wrap;
            if (line_wrap && (frm_cnt != '1)) begin
                frm_cnt <= frm_cnt + FRM_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        sh_pix_max  <= pix_max;
                        sh_line_max <= line_max;
                        sh_mode     <= mode;
                    end
                end
                RUN: begin
                    if (line_wrap && sh_mode) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // Waiting for start to drop keeps a held-high start from retriggering.
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_timer.sv
// tb/tb_frame_timer.sv - randomized and directed self-checking bench for frame_timer
module tb_frame_timer;

    localparam int PW   = 6;
    localparam int LW   = 5;
    localparam int FW   = 2;
    localparam int FMAX = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          clr;
    logic          start;
    logic          mode;
    logic [PW-1:0] pix_max;
    logic [LW-1:0] line_max;
    logic [PW-1:0] pix_idx;
    logic [LW-1:0] line_idx;
    logic          newLine;
    logic          endFrame;
    logic          busy;
    logic [FW-1:0] frm_cnt;

    always #5 clk = ~clk;

    frame_timer #(.PIX_W(PW), .LINE_W(LW), .FRM_W(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .clr      (clr),
        .start    (start),
        .mode     (mode),
        .pix_max  (pix_max),
        .line_max (line_max),
        .pix_idx  (pix_idx),
        .line_idx (line_idx),
        .newLine  (newLine),
        .endFrame (endFrame),
        .busy     (busy),
        .frm_cnt  (frm_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: position in the frame is a single tick count t; indices derive from it.
    int m_st;
    int m_t;
    int m_P;
    int m_L;
    int m_frm;
    bit m_sm;
    bit m_nl;
    bit m_ef;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_P = 0; m_L = 0; m_frm = 0;
        m_sm = 0; m_nl = 0; m_ef = 0;
    endtask

    task automatic model_step();
        if (clr) begin
            m_st = 0; m_t = 0; m_nl = 0; m_ef = 0; m_frm = 0;
            return;
        end
        m_nl = 0;
        m_ef = 0;
        if (m_st == 0) begin
            if (start) begin
                m_st = 1;
                m_P  = int'(pix_max);
                m_L  = int'(line_max);
                m_sm = mode;
            end
        end else if (m_st == 1) begin
            if (enb) begin
                m_t++;
                if (m_t % (m_P + 1) == 0) m_nl = 1;
                if (m_t == (m_P + 1) * (m_L + 1)) begin
                    m_t  = 0;
                    m_ef = 1;
                    if (m_frm < FMAX) m_frm++;
                    if (m_sm) m_st = 2;
                end
            end
        end else begin
            if (!start) m_st = 0;
        end
    endtask

    task automatic compare_all();
        chk("pix_idx",  int'(pix_idx),  m_t % (m_P + 1));
        chk("line_idx", int'(line_idx), m_t / (m_P + 1));
        chk("newLine",  int'(newLine),  int'(m_nl));
        chk("endFrame", int'(endFrame), int'(m_ef));
        chk("busy",     int'(busy),     (m_st == 1) ? 1 : 0);
        chk("frm_cnt",  int'(frm_cnt),  m_frm);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    task automatic set_in(input bit s, input bit e, input bit m, input int p, input int l);
        start = s; enb = e; mode = m; clr = 1'b0;
        pix_max = PW'(p); line_max = LW'(l);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int nl_cnt;
    int ef_cnt;

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; enb = 1'b0; mode = 1'b0;
        pix_max = '0; line_max = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_pix", int'(pix_idx), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frm", int'(frm_cnt), 0);
        chk("reset_ef", int'(endFrame), 0);
        rst = 1'b0;
        tick();

        // Free-run 4x3 frame
        set_in(1, 1, 0, 3, 2);
        tick();
        start = 1'b0;
        nl_cnt = 0; ef_cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (newLine) nl_cnt++;
            if (endFrame) ef_cnt++;
            if (i == 4) chk("fr_first_newline", int'(newLine), 1);
            if (i == 12) chk("fr_first_endframe", int'(endFrame), 1);
        end
        chk("fr_newline_count", nl_cnt, 9);
        chk("fr_endframe_count", ef_cnt, 3);
        chk("fr_frm_cnt", int'(frm_cnt), 3);

        // Single-shot with start held high
        do_clear();
        set_in(1, 1, 1, 3, 2);
        ef_cnt = 0;
        for (int i = 0; i < 23; i++) begin
            tick();
            if (endFrame) ef_cnt++;
        end
        chk("ss_one_endframe", ef_cnt, 1);
        chk("ss_hold_busy", int'(busy), 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("ss_restart_busy", int'(busy), 1);

        // Pause at pix 2 / line 1
        do_clear();
        set_in(1, 1, 0, 3, 2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pause_pix", int'(pix_idx), 2);
            chk("pause_line", int'(line_idx), 1);
            chk("pause_no_pulse", int'(newLine | endFrame), 0);
        end
        enb = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pause_not_yet", int'(endFrame), 0);
        tick();
        chk("pause_late_endframe", int'(endFrame), 1);

        // Both maxima zero, saturation at FW bits
        do_clear();
        set_in(1, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("zero_newline", int'(newLine), 1);
            chk("zero_endframe", int'(endFrame), 1);
        end
        chk("sat_frm_cnt", int'(frm_cnt), 3);

        // Clear and start together
        clr = 1'b1; start = 1'b1;
        tick();
        chk("clr_busy", int'(busy), 0);
        chk("clr_frm", int'(frm_cnt), 0);
        clr = 1'b0; start = 1'b0;
        tick();
        chk("clr_idle", int'(busy), 0);

        // Async reset at pix 1 / line 2
        set_in(1, 1, 0, 3, 2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst_pix", int'(pix_idx), 1);
        chk("pre_rst_line", int'(line_idx), 2);
        async_reset();
        ef_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (endFrame) ef_cnt++;
        end
        chk("rst_no_endframe", ef_cnt, 0);
        chk("rst_waits_idle", int'(busy), 0);

        // Shadowed limits
        set_in(1, 1, 0, 3, 2);
        tick();
        start = 1'b0;
        pix_max = PW'(7);
        for (int i = 0; i < 4; i++) tick();
        chk("shadow_newline", int'(newLine), 1);
        chk("shadow_line", int'(line_idx), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr      = ($urandom_range(0, 99) < 2);
            start    = ($urandom_range(0, 99) < 30);
            enb      = ($urandom_range(0, 99) < 80);
            mode     = 1'($urandom_range(0, 1));
            pix_max  = PW'($urandom_range(0, 5));
            line_max = LW'($urandom_range(0, 3));
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_timer.md
FRAME_TIMER -- requirements
Module: frame_timer

Interface
REQ-001 SHALL have parameter PIX_W, default 6: width of the pixel counter.
REQ-002 SHALL have parameter LINE_W, default 5: width of the line counter.
REQ-003 SHALL have parameter FRM_W, default 8: width of the completed-frame counter.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
  clk        in   1       master clock; single clock domain
  rst        in   1       asynchronous, active-high reset
  enb        in   1       active-high count enable; low = pause
  clr        in   1       synchronous clear to IDLE
  start      in   1       level; begins a frame sequence
  mode       in   1       0 = free-run, 1 = single-shot
  pix_max    in   PIX_W   last pixel index of a line
  line_max   in   LINE_W  last line index of a frame
  pix_idx    out  PIX_W   current pixel index
  line_idx   out  LINE_W  current line index
  newLine    out  1       one-cycle pulse: a line wrapped
  endFrame   out  1       one-cycle pulse: a frame completed
  busy       out  1       high while in RUN
  frm_cnt    out  FRM_W   completed frames, saturating

Function
REQ-005 SHALL implement states IDLE, RUN and HOLD.
REQ-006 IDLE SHALL hold both indices at 0 and busy at 0; start=1 moves the block to RUN on the next edge.
REQ-007 On the IDLE->RUN edge, pix_max, line_max and mode SHALL be latched into shadow registers; input changes during RUN SHALL have no effect until the next start.
REQ-008 RUN with enb=1: pix_idx SHALL increment by 1 per cycle; at shadow pix_max it SHALL wrap to 0 and line_idx SHALL increment.
REQ-009 RUN with enb=0: indices SHALL freeze and no pulses SHALL be generated.
REQ-010 newLine SHALL be a registered pulse, high in the cycle after pix_idx wraps from pix_max to 0, including the wrap that ends the frame.
REQ-011 At pix_idx=pix_max and line_idx=line_max with enb=1, both indices SHALL wrap to 0 and endFrame SHALL pulse high in the next cycle, coincident with newLine.
REQ-012 On frame end in free-run mode, the block SHALL stay in RUN. In single-shot mode it SHALL go to HOLD.
REQ-013 HOLD SHALL keep the indices at 0 and busy at 0, and SHALL go to IDLE only when start=0. A held-high start SHALL NOT retrigger.
REQ-014 frm_cnt SHALL increment on every endFrame and SHALL saturate at all ones.
REQ-015 With pix_max=0, every enabled RUN cycle SHALL be a line wrap. With both maxima 0, every enabled RUN cycle SHALL end a frame.
REQ-016 clr=1 SHALL force IDLE and zero the indices, pulses and frm_cnt. clr SHALL win over start, enb and frame end.
REQ-017 start=1 while in RUN SHALL be ignored.
REQ-018 All outputs SHALL be registered. There SHALL be no combinational path from inputs to outputs.

Reset
REQ-019 rst=1 SHALL asynchronously force IDLE, and SHALL force pix_idx, line_idx, newLine, endFrame, busy, frm_cnt and the shadow registers to 0.
REQ-020 rst asserted mid-frame SHALL abort the frame with no endFrame pulse. After release, the block SHALL wait in IDLE for start.

Structure
REQ-021 Package frame_pkg SHALL hold the state encoding (IDLE, RUN, HOLD) and the default values of PIX_W, LINE_W and FRM_W.
REQ-022 A sub-module wrap_counter SHALL be used: a parametrised width, with en, max and clr inputs, and count and wrap outputs. It SHALL be instantiated twice, once for pixels and once for lines.

Verification
REQ-023 Free-run: pix_max=3, line_max=2, mode=0, enb=1, start pulse -> newLine every 4 cycles; endFrame every 12 cycles; frm_cnt=3 after 36 RUN cycles.
REQ-024 Single-shot: same limits, mode=1, start held high -> exactly one endFrame, then HOLD with busy=0; no restart until start drops and rises again.
REQ-025 Pause: deassert enb for 5 cycles at pix_idx=2, line_idx=1 -> indices frozen with no pulses; frame completes 5 cycles late.
REQ-026 Boundaries: pix_max=0, line_max=0 -> endFrame and newLine high every enabled cycle. With FRM_W=2 and 5 frames, frm_cnt stays at 3.
REQ-027 Clear and reset: clr with start on the same cycle -> IDLE with frm_cnt=0. Async rst at pix_idx=1, line_idx=2 -> all outputs 0 immediately and no endFrame.
REQ-028 Shadowing: change pix_max from 3 to 7 mid-frame -> line length stays 4 until the next start.
